// File: rtl/maes_pkg.sv
// ============================================================================
//  Module      : maes_pkg
//  Description : Shared types and constants for the Modified AES-128 round
//                sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package maes_pkg;

  localparam int MAES_BLK_W      = 128;
  localparam int MAES_RND_W      = 4;
  localparam int MAES_NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } maes_ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/maes_round_ctrl.sv
// ============================================================================
//  Module      : maes_round_ctrl
//  Description : Round sequencer for the Modified AES-128 encrypt path.
//                Accepts a plaintext/key pair, applies the initial
//                AddRoundKey, drives NUM_ROUNDS round operations through an
//                external datapath of latency DP_LAT and returns the
//                ciphertext. One block in flight at a time.
//                Optional feature macro: MAES_PERF_CNT_EN adds a saturating
//                32-bit count of non-idle cycles on port perf_cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module maes_round_ctrl
  import maes_pkg::*;
#(
  parameter int NUM_ROUNDS = MAES_NUM_ROUNDS,
  parameter int DP_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MAES_BLK_W-1:0] in_data,
  input  logic [MAES_BLK_W-1:0] in_key,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MAES_BLK_W-1:0] out_data,
  output logic                  rnd_start,
  output logic [MAES_BLK_W-1:0] rnd_data,
  output logic [MAES_RND_W-1:0] rnd_num,
  output logic                  rnd_final,
  output logic [MAES_BLK_W-1:0] cipher_key,
  input  logic [MAES_BLK_W-1:0] rnd_result
`ifdef MAES_PERF_CNT_EN
  ,
  output logic [31:0]           perf_cycles
`endif
);

  localparam logic [MAES_RND_W-1:0] c_LAST_RND = MAES_RND_W'(NUM_ROUNDS);
  localparam logic [MAES_RND_W-1:0] c_LAT_LOAD = MAES_RND_W'(DP_LAT - 1);

  maes_ctrl_state_t        r_state;
  maes_ctrl_state_t        w_state_nxt;
  logic [MAES_BLK_W-1:0]   r_blk;        // running cipher state
  logic [MAES_BLK_W-1:0]   r_cipher_key;
  logic [MAES_RND_W-1:0]   r_round;
  logic [MAES_RND_W-1:0]   r_lat_cnt;
  logic                    r_rnd_start;
  logic                    r_out_valid;
  logic                    w_last_rnd;
  logic                    w_lat_done;

  assign w_last_rnd = (r_round == c_LAST_RND);
  assign w_lat_done = (r_lat_cnt == '0);

  // The running state doubles as the round input and, once the last round
  // has been captured, as the ciphertext; it is frozen in OUT.
  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = r_out_valid;
  assign out_data   = r_blk;
  assign rnd_start  = r_rnd_start;
  assign rnd_data   = r_blk;
  assign rnd_num    = r_round;
  assign rnd_final  = w_last_rnd;
  assign cipher_key = r_cipher_key;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode: one ISSUE cycle per round, then DP_LAT WAIT cycles.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid)  w_state_nxt = ST_ISSUE;
      ST_ISSUE:                w_state_nxt = ST_WAIT;
      ST_WAIT:  if (w_lat_done) w_state_nxt = w_last_rnd ? ST_OUT : ST_ISSUE;
      ST_OUT:   if (out_ready) w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  // Block state, round/latency counters and registered handshake strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blk        <= '0;
      r_cipher_key <= '0;
      r_round      <= '0;
      r_lat_cnt    <= '0;
      r_rnd_start  <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      r_rnd_start <= (w_state_nxt == ST_ISSUE);
      r_out_valid <= (w_state_nxt == ST_OUT);
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_blk        <= in_data ^ in_key;
            r_cipher_key <= in_key;
            r_round      <= MAES_RND_W'(1);
          end
        end
        ST_ISSUE: r_lat_cnt <= c_LAT_LOAD;
        ST_WAIT: begin
          if (w_lat_done) begin
            r_blk <= rnd_result;
            if (!w_last_rnd) r_round <= r_round + MAES_RND_W'(1);
          end else begin
            r_lat_cnt <= r_lat_cnt - MAES_RND_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MAES_PERF_CNT_EN
  logic [31:0] r_perf_cycles;

  assign perf_cycles = r_perf_cycles;

  // Saturating count of cycles spent outside IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_cycles <= '0;
    end else if ((r_state != ST_IDLE) && (r_perf_cycles != 32'hFFFF_FFFF)) begin
      r_perf_cycles <= r_perf_cycles + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_maes_round_ctrl.sv
// ============================================================================
//  Module      : tb_maes_round_ctrl
//  Description : Scoreboard bench for maes_round_ctrl. Instance 0 runs with
//                DP_LAT=1, instance 1 with DP_LAT=3; both use 10 rounds and a
//                stub datapath returning rnd_data ^ rnd_num after DP_LAT
//                cycles. With MAES_PERF_CNT_EN defined the perf counter is
//                also checked.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_maes_round_ctrl;

  localparam int NR = 10;

  logic clk = 1'b0;
  logic rst;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  logic         in_valid [2];
  logic         in_ready [2];
  logic         out_valid[2];
  logic         out_ready[2];
  logic         rnd_start[2];
  logic         rnd_final[2];
  logic [127:0] in_data  [2];
  logic [127:0] in_key   [2];
  logic [127:0] out_data [2];
  logic [127:0] rnd_data [2];
  logic [127:0] cipher_key[2];
  logic [127:0] rnd_result[2];
  logic [3:0]   rnd_num  [2];
`ifdef MAES_PERF_CNT_EN
  logic [31:0]  perf     [2];
`endif

  logic [127:0] exp_q[2][$];

  always #5 clk = ~clk;

  // Cycle index; stable when sampled on the falling edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int inst,
                       input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s inst%0d: got %h want %h", nm, inst, got, want);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;

    maes_round_ctrl #(.NUM_ROUNDS(NR), .DP_LAT(L)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_data    (in_data[g]),
      .in_key     (in_key[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .out_data   (out_data[g]),
      .rnd_start  (rnd_start[g]),
      .rnd_data   (rnd_data[g]),
      .rnd_num    (rnd_num[g]),
      .rnd_final  (rnd_final[g]),
      .cipher_key (cipher_key[g]),
      .rnd_result (rnd_result[g])
`ifdef MAES_PERF_CNT_EN
      ,
      .perf_cycles(perf[g])
`endif
    );

    // Stub round datapath: XOR in the round number, L-cycle pipeline.
    logic [127:0] pipe[L];
    always @(posedge clk) begin
      pipe[0] <= rnd_data[g] ^ {124'b0, rnd_num[g]};
      for (int j = 1; j < L; j++) pipe[j] <= pipe[j-1];
    end
    assign rnd_result[g] = pipe[L-1];

    // Monitor: tracks the block in flight and checks every round issue and
    // every cycle of out_valid against the scoreboard queue.
    bit           busy   = 1'b0;
    bit           seen_v = 1'b0;
    int           acc_cyc, rnd, nxt;
    logic [127:0] st, key_m;

    always @(negedge clk) begin
      if (rst) begin
        busy   = 1'b0;
        seen_v = 1'b0;
      end else begin
        check("in_ready", g, in_ready[g], !busy);
        if (in_valid[g] && in_ready[g]) begin
          busy    = 1'b1;
          acc_cyc = cyc;
          st      = in_data[g] ^ in_key[g];
          key_m   = in_key[g];
          rnd     = 1;
          nxt     = cyc + 1;
        end
        if (rnd_start[g]) begin
          check("rnd_start_time", g, cyc, nxt);
          check("rnd_num", g, rnd_num[g], rnd);
          check("rnd_final", g, rnd_final[g], rnd == NR);
          check("rnd_data", g, rnd_data[g], st);
          check("cipher_key", g, cipher_key[g], key_m);
          st  = st ^ {124'b0, rnd[3:0]};
          rnd = rnd + 1;
          nxt = nxt + L + 1;
        end
        if (out_valid[g]) begin
          if (exp_q[g].size() == 0) begin
            check("out_valid_unexpected", g, 1, 0);
          end else begin
            if (!seen_v) begin
              check("out_latency", g, cyc - acc_cyc, 1 + NR * (L + 1));
              check("rounds_issued", g, rnd - 1, NR);
            end
            check("out_data", g, out_data[g], exp_q[g][0]);
            seen_v = 1'b1;
            if (out_ready[g]) begin
              void'(exp_q[g].pop_front());
              busy   = 1'b0;
              seen_v = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [127:0] d,
                      input logic [127:0] k, input logic [127:0] e);
    int n = 0;
    step();
    in_data[i]  = d;
    in_key[i]   = k;
    in_valid[i] = 1'b1;
    exp_q[i].push_back(e);
    while (!in_ready[i] && n < 300) begin
      step();
      n++;
    end
    check("accept_timeout", i, in_ready[i], 1'b1);
    step();
    in_valid[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    int n = 0;
    while (exp_q[i].size() != 0 && n < 500) begin
      step();
      n++;
    end
    check("drain", i, exp_q[i].size(), 0);
  endtask

  task automatic chk_zero(input int i);
    check("rst_out_valid", i, out_valid[i], 0);
    check("rst_out_data", i, out_data[i], 0);
    check("rst_rnd_start", i, rnd_start[i], 0);
    check("rst_rnd_data", i, rnd_data[i], 0);
    check("rst_rnd_num", i, rnd_num[i], 0);
    check("rst_rnd_final", i, rnd_final[i], 0);
    check("rst_cipher_key", i, cipher_key[i], 0);
    check("rst_in_ready", i, in_ready[i], 1);
  endtask

  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] V2_D = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] V2_E = 128'h0123456789ABCDEF_FEDCBA987654321B;

  initial begin
    int n;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = '0;
      in_key[i]    = '0;
      out_ready[i] = 1'b1;
    end
    repeat (3) step();
    chk_zero(0);
    chk_zero(1);
    rst = 1'b0;

    // All-zero block: XOR of round numbers 1..10 is 0x0B.
    send(0, '0, '0, 128'h0B);
    wait_done(0);

    // Plaintext equals key: round-1 input is zero.
    send(0, ONES, ONES, 128'h0B);
    wait_done(0);

    // Back-pressure: sink stalls 5 cycles, in_valid pulsed meanwhile.
    out_ready[0] = 1'b0;
    send(0, 128'hF0, 128'h0F, 128'hF4);
    n = 0;
    while (!out_valid[0] && n < 100) begin
      step();
      n++;
    end
    check("out_valid_timeout", 0, out_valid[0], 1);
    in_data[0]  = 128'hDEAD;
    in_key[0]   = 128'hBEEF;
    for (int c = 0; c < 5; c++) begin
      in_valid[0] = (c % 2 == 0);
      step();
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    wait_done(0);

    // Reset during round 4 abandons the block.
    send(0, '0, '0, 128'h0B);
    n = 0;
    while (!(rnd_num[0] == 4'd4 && !rnd_start[0]) && n < 100) begin
      step();
      n++;
    end
    check("round4_timeout", 0, rnd_num[0], 4);
    exp_q[0].delete();
    rst = 1'b1;
    step();
    chk_zero(0);
    rst = 1'b0;
    send(0, '0, '0, 128'h0B);
    wait_done(0);
    send(0, V2_D, '0, V2_E);
    wait_done(0);

    // Longer datapath latency on instance 1.
    send(1, '0, '0, 128'h0B);
    send(1, V2_D, '0, V2_E);
    wait_done(1);

`ifdef MAES_PERF_CNT_EN
    rst = 1'b1;
    step();
    check("perf_rst", 0, perf[0], 0);
    rst = 1'b0;
    send(0, '0, '0, 128'h0B);
    send(0, '0, '0, 128'h0B);
    wait_done(0);
    step();
    check("perf_cycles", 0, perf[0], 42);
`endif

    repeat (5) step();
    check("q0_empty", 0, exp_q[0].size(), 0);
    check("q1_empty", 1, exp_q[1].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
